// File: rtl/fma_operand_sequencer.sv
// Dot-product front end for the FMA accumulator: fetches operand pairs
// from two scratchpad ports, seeds the accumulator, streams beats, returns the sum.
module fma_operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int AW      = 8,
  parameter int MAX_K   = 16,
  parameter int FMA_LAT = 1,
  parameter int KW      = $clog2(MAX_K+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [KW-1:0]    cmd_len,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [AW-1:0]    cmd_base_a,
  input  logic [AW-1:0]    cmd_base_b,
  input  logic [AW-1:0]    cmd_stride_b,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_a_addr,
  output logic [AW-1:0]    mem_b_addr,
  input  logic [WIDTH-1:0] mem_a_data,
  input  logic [WIDTH-1:0] mem_b_data,
  output logic [WIDTH-1:0] fma_a,
  output logic [WIDTH-1:0] fma_b,
  output logic [WIDTH-1:0] fma_seed,
  output logic             fma_update_acc,
  output logic             fma_input_good,
  input  logic             fma_in_ready,
  input  logic [WIDTH-1:0] fma_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);

  localparam int LW = $clog2(FMA_LAT+1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_STREAM, S_DRAIN, S_RESULT
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     len_q, len_d;
  logic [KW-1:0]     iss_q, iss_d;
  logic [KW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  seed_q, seed_d;
  logic [AW-1:0]     a_addr_q, a_addr_d;
  logic [AW-1:0]     b_addr_q, b_addr_d;
  logic [AW-1:0]     stride_q, stride_d;
  logic              infl_q, infl_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [LW-1:0]     drn_q, drn_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  fa_q [2];
  logic [WIDTH-1:0]  fb_q [2];

  logic in_good, accept, bypass, issue, push, pop;

  // With an empty FIFO the head is the read returning this cycle, so the
  // first beat need not wait for a FIFO write.
  always_comb begin
    bypass  = (cnt_q == 2'd0);
    in_good = (state_q == S_STREAM) && (!bypass || infl_q);
    accept  = in_good && fma_in_ready;
    issue   = (state_q == S_STREAM) && (iss_q < len_q) &&
              ((cnt_q + {1'b0, infl_q}) < 2'd2);
    push    = infl_q && !(bypass && accept);
    pop     = accept && !bypass;
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    iss_d    = iss_q;
    acc_d    = acc_q;
    seed_d   = seed_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    stride_d = stride_q;
    drn_d    = drn_q;
    res_d    = res_q;
    infl_d   = issue;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_d     = wr_q ^ push;
    rd_d     = rd_q ^ pop;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_SEED;
          len_d    = (cmd_len > KW'(MAX_K)) ? KW'(MAX_K) : cmd_len;
          seed_d   = cmd_seed;
          a_addr_d = cmd_base_a;
          b_addr_d = cmd_base_b;
          stride_d = cmd_stride_b;
          iss_d    = '0;
          acc_d    = '0;
        end
      end
      S_SEED: begin
        state_d = (len_q != '0) ? S_STREAM : S_DRAIN;
        drn_d   = '0;
      end
      S_STREAM: begin
        if (issue) begin
          a_addr_d = a_addr_q + AW'(1);
          b_addr_d = b_addr_q + stride_q;
          iss_d    = iss_q + KW'(1);
        end
        if (accept) begin
          acc_d = acc_q + KW'(1);
          if (acc_d == len_q) begin
            state_d = S_DRAIN;
            drn_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drn_q == LW'(FMA_LAT-1)) begin
          res_d   = fma_acc;
          state_d = S_RESULT;
        end else begin
          drn_d = drn_q + LW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      iss_q    <= '0;
      acc_q    <= '0;
      seed_q   <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      stride_q <= '0;
      infl_q   <= 1'b0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      drn_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      iss_q    <= iss_d;
      acc_q    <= acc_d;
      seed_q   <= seed_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      stride_q <= stride_d;
      infl_q   <= infl_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      drn_q    <= drn_d;
      res_q    <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wr_q] <= mem_a_data;
      fb_q[wr_q] <= mem_b_data;
    end
  end

  always_comb begin
    cmd_ready      = (state_q == S_IDLE);
    mem_rd_en      = issue;
    mem_a_addr     = a_addr_q;
    mem_b_addr     = b_addr_q;
    fma_update_acc = (state_q == S_SEED);
    fma_seed       = fma_update_acc ? seed_q : '0;
    fma_input_good = in_good;
    fma_a          = '0;
    fma_b          = '0;
    if (in_good) begin
      fma_a = bypass ? mem_a_data : fa_q[rd_q];
      fma_b = bypass ? mem_b_data : fb_q[rd_q];
    end
    res_valid = (state_q == S_RESULT);
    res_data  = res_q;
  end

endmodule
